// File: rtl/button_event_if.sv
// Button gesture bus: debounced level in, one-cycle event pulses and held level out.
interface button_event_if;
  logic i_btn;
  logic o_short;
  logic o_long;
  logic o_double;
  logic o_repeat;
  logic o_held;

  modport master (
    output i_btn,
    input  o_short,
    input  o_long,
    input  o_double,
    input  o_repeat,
    input  o_held
  );

  modport slave (
    input  i_btn,
    output o_short,
    output o_long,
    output o_double,
    output o_repeat,
    output o_held
  );
endinterface

// File: rtl/button_event.sv
// Gesture classifier: short / long / double-click pulses from a debounced button level.
// Optional auto-repeat while held long is built only with BUTTON_EVENT_REPEAT_EN defined.
module button_event #(
  parameter int LONG_CLOCKS   = 50_000_000,
  parameter int DOUBLE_CLOCKS = 25_000_000,
  parameter int REPEAT_CLOCKS = 10_000_000
) (
  input  logic          clk,
  input  logic          rst,
  button_event_if.slave bus
);

  localparam int MAX_LD     = (LONG_CLOCKS > DOUBLE_CLOCKS) ? LONG_CLOCKS : DOUBLE_CLOCKS;
  localparam int MAX_CLOCKS = (MAX_LD > REPEAT_CLOCKS) ? MAX_LD : REPEAT_CLOCKS;
  localparam int CNT_W      = $clog2(MAX_CLOCKS);

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CLOCKS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CLOCKS - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CLOCKS - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_HOLD2 = 3'd3,
    ST_LONG  = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             btn_q_r;
  logic             armed_r;
  logic             short_r;
  logic             long_r;
  logic             double_r;
`ifdef BUTTON_EVENT_REPEAT_EN
  logic             rpt_r;
`endif

  // Gesture FSM with the shared counter and all registered event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      btn_q_r  <= 1'b0;
      armed_r  <= 1'b0;
      short_r  <= 1'b0;
      long_r   <= 1'b0;
      double_r <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      rpt_r    <= 1'b0;
`endif
    end else begin
      btn_q_r  <= bus.i_btn;
      // A press only counts once the button has been seen released after reset.
      armed_r  <= armed_r | ~bus.i_btn;
      short_r  <= 1'b0;
      long_r   <= 1'b0;
      double_r <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      rpt_r    <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (bus.i_btn && !btn_q_r && armed_r) begin
            state_r <= ST_HOLD;
            cnt_r   <= CNT_ZERO;
          end
        end
        ST_HOLD: begin
          if (!bus.i_btn) begin
            state_r <= ST_GAP;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == LONG_LAST) begin
            state_r <= ST_LONG;
            cnt_r   <= CNT_ZERO;
            long_r  <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        ST_GAP: begin
          // The second press wins over a timeout on the same edge.
          if (bus.i_btn) begin
            state_r  <= ST_HOLD2;
            cnt_r    <= CNT_ZERO;
            double_r <= 1'b1;
          end else if (cnt_r == DOUBLE_LAST) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            short_r  <= 1'b1;
          end else begin
            cnt_r    <= cnt_r + CNT_ONE;
          end
        end
        ST_HOLD2: begin
          if (!bus.i_btn) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end
        end
        ST_LONG: begin
          if (!bus.i_btn) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
          end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
            if (cnt_r == REPEAT_LAST) begin
              cnt_r <= CNT_ZERO;
              rpt_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
`else
            cnt_r <= cnt_r;
`endif
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.o_short  = short_r;
  assign bus.o_long   = long_r;
  assign bus.o_double = double_r;
  assign bus.o_held   = btn_q_r;
`ifdef BUTTON_EVENT_REPEAT_EN
  assign bus.o_repeat = rpt_r;
`else
  assign bus.o_repeat = 1'b0;
`endif

endmodule
